stream_sorter8: RTL and testbench

- Sequential sorting stage built around the 8-bit tree comparator: accepts a burst of N unsigned 8-bit words, sorts them ascending, then streams them out.
- Uses a single comparator instance, time-multiplexed over a bubble-sort schedule.
- Sits between an upstream valid/ready byte source and a downstream valid/ready consumer.

---
 rtl/stream_sorter8_pkg.sv | 19 +
 rtl/stream_sorter8_cmp.sv | 33 +++
 rtl/stream_sorter8.sv | 172 +++++++++++++++++
 tb/tb_stream_sorter8.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_sorter8_pkg.sv
// Shared types and constants for the stream_sorter8 sorting stage.
// Also holds the merge step used by the tree comparator.
package stream_sorter8_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  // Node encoding is {gt, eq}; the high half decides unless it is equal.
  function automatic logic [1:0] cmp_merge(input logic [1:0] hi, input logic [1:0] lo);
    return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
  endfunction

endpackage

// File: rtl/stream_sorter8_cmp.sv
// cmp8_gt_eq: combinational 8-bit unsigned tree comparator.
// Bit-level {gt, eq} nodes are merged pairwise over three levels.
module cmp8_gt_eq
  import stream_sorter8_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              gt,
  output logic              eq
);

  logic [1:0] lvl0 [8];
  logic [1:0] lvl1 [4];
  logic [1:0] lvl2 [2];
  logic [1:0] root;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign lvl0[i] = {a[i] & ~b[i], ~(a[i] ^ b[i])};
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    assign lvl1[i] = cmp_merge(lvl0[2*i+1], lvl0[2*i]);
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    assign lvl2[i] = cmp_merge(lvl1[2*i+1], lvl1[2*i]);
  end

  assign root = cmp_merge(lvl2[1], lvl2[0]);
  assign gt   = root[1];
  assign eq   = root[0];

endmodule

// File: rtl/stream_sorter8.sv
// stream_sorter8: loads N bytes, bubble-sorts them with one shared comparator, streams them out.
// Build option SORTER_EARLY_EXIT_EN: leave SORT after the first pass that makes no swap.
//
// state | meaning
// LOAD  | accepting input words into the buffer
// SORT  | one compare (and optional swap) per cycle
// DRAIN | presenting sorted words to the consumer
module stream_sorter8
  import stream_sorter8_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);

  if (W != WORD_W) begin : g_bad_width
    $error("stream_sorter8: W must be 8 to match cmp8_gt_eq");
  end
  if (N < 2 || N > 8) begin : g_bad_depth
    $error("stream_sorter8: N must be in 2..8");
  end

  state_t           state;
  logic [W-1:0]     mem [N];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] pass_idx;
  logic [IDX_W-1:0] cmp_idx;
  logic [W-1:0]     cmp_a;
  logic [W-1:0]     cmp_b;
  logic [W-1:0]     rd_word;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             swap;
  logic             load_fire;
  logic             pass_end;
  logic             sort_done;

  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (cmp_idx == IDX_W'(i)) begin
        cmp_a = mem[i];
        cmp_b = mem[i+1];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = mem[i];
    end
  end

  cmp8_gt_eq u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  assign in_ready  = (state == LOAD) && !rst;
  assign load_fire = in_valid && in_ready;
  // Equal keys never swap, which keeps the sort stable.
  assign swap      = (state == SORT) && cmp_gt && !cmp_eq;
  assign pass_end  = (cmp_idx == LAST_PASS - pass_idx);
  assign out_data  = out_valid ? rd_word : '0;

`ifdef SORTER_EARLY_EXIT_EN
  logic swapped;

  assign sort_done = pass_end && ((pass_idx == LAST_PASS) || !(swapped || swap));

  always_ff @(posedge clk) begin
    if (rst) begin
      swapped <= 1'b0;
    end else if (state == SORT) begin
      swapped <= pass_end ? 1'b0 : (swapped | swap);
    end
  end
`else
  assign sort_done = pass_end && (pass_idx == LAST_PASS);
`endif

  // Buffer is not reset; its contents are only meaningful after a full LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (load_fire && wr_idx == IDX_W'(i)) begin
          mem[i] <= in_data;
        end else if (swap && cmp_idx == IDX_W'(i)) begin
          mem[i] <= cmp_b;
        end else if (swap && i > 0 && cmp_idx == IDX_W'(i - 1)) begin
          mem[i] <= cmp_a;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_idx    <= '0;
      rd_idx    <= '0;
      pass_idx  <= '0;
      cmp_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_fire) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              state  <= SORT;
              busy   <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          if (sort_done) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            pass_idx  <= '0;
            cmp_idx   <= '0;
          end else if (pass_end) begin
            pass_idx <= pass_idx + 1'b1;
            cmp_idx  <= '0;
          end else begin
            cmp_idx <= cmp_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx    <= '0;
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              rd_idx   <= rd_idx + 1'b1;
              out_last <= (rd_idx == LAST_IDX - 1'b1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sorter8.sv
// Directed self-checking bench for stream_sorter8 (N=4).
// Expected sort latency for sorted input depends on SORTER_EARLY_EXIT_EN.
module tb_stream_sorter8;

  typedef logic [7:0] burst_t [4];

  localparam int EXP_FULL_LAT = 7;
`ifdef SORTER_EARLY_EXIT_EN
  localparam int EXP_SORTED_LAT = 4;
`else
  localparam int EXP_SORTED_LAT = 7;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int swap_cnt = 0;

  stream_sorter8 #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dut.swap) swap_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input int gap, input bit hold, output bit ok);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    ok = in_ready;
    tick();
    if (hold) begin
      in_data = 8'h77;
    end else begin
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
    repeat (gap) tick();
  endtask

  task automatic send_burst(input burst_t w, input int gap, input bit hold, output int ok_cnt);
    bit ok;
    ok_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(w[i], (i == 3) ? 0 : gap, hold && (i == 3), ok);
      ok_cnt += int'(ok);
    end
  endtask

  // mode 0: out_ready always high; mode 1: ready pattern 1,0,0 over valid cycles
  task automatic drain_burst(input int mode, output burst_t got, output logic [3:0] lasts,
                             output int n, output int first_hs, output int stall_err,
                             output int rdy_err);
    int c = 0;
    int vc = 0;
    bit stalled = 1'b0;
    logic [7:0] sd = 8'h00;
    logic sl = 1'b0;
    n = 0; first_hs = -1; stall_err = 0; rdy_err = 0; lasts = 4'b0000;
    got = '{default: 8'h00};
    while (n < 4 && c < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (vc % 3 == 0);
      if (in_ready) rdy_err++;
      if (out_valid) begin
        if (stalled && (out_data !== sd || out_last !== sl)) stall_err++;
        if (out_ready) begin
          got[n]   = out_data;
          lasts[n] = out_last;
          if (first_hs < 0) first_hs = c + 1;
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sd = out_data;
          sl = out_last;
        end
        vc++;
      end
      tick();
      c++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reverse();
    burst_t w, exp, got;
    logic [3:0] lasts;
    int ok_cnt, n, fhs, serr, rerr;
    w   = '{8'h40, 8'h30, 8'h20, 8'h10};
    exp = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_burst(w, 0, 1'b0, ok_cnt);
    checks++; if (ok_cnt != 4) begin failures++; $display("FAIL reverse_accept got=%0d exp=4", ok_cnt); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL reverse_sort_flags busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    drain_burst(0, got, lasts, n, fhs, serr, rerr);
    checks++; if (n != 4) begin failures++; $display("FAIL reverse_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL reverse_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL reverse_last got=%b exp=1000", lasts); end
    checks++; if (fhs != EXP_FULL_LAT) begin failures++; $display("FAIL reverse_latency got=%0d exp=%0d", fhs, EXP_FULL_LAT); end
    checks++; if (rerr != 0) begin failures++; $display("FAIL reverse_in_ready_busy got=%0d exp=0", rerr); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reverse_back_to_load in_ready=%b busy=%b exp 1/0", in_ready, busy); end
  endtask

  task automatic test_duplicates();
    burst_t w, exp, got;
    logic [3:0] lasts;
    int ok_cnt, n, fhs, serr, rerr, s0;
    w   = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    exp = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    s0 = swap_cnt;
    send_burst(w, 0, 1'b0, ok_cnt);
    drain_burst(0, got, lasts, n, fhs, serr, rerr);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL dup_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (swap_cnt - s0 != 3) begin failures++; $display("FAIL dup_swaps got=%0d exp=3", swap_cnt - s0); end
    checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL dup_last got=%b exp=1000", lasts); end
  endtask

  task automatic test_backpressure();
    burst_t w, exp, got;
    logic [3:0] lasts;
    int ok_cnt, n, fhs, serr, rerr;
    w   = '{8'h05, 8'h03, 8'h09, 8'h01};
    exp = '{8'h01, 8'h03, 8'h05, 8'h09};
    send_burst(w, 0, 1'b0, ok_cnt);
    drain_burst(1, got, lasts, n, fhs, serr, rerr);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (serr != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", serr); end
    checks++; if (rerr != 0) begin failures++; $display("FAIL bp_in_ready_early got=%0d exp=0", rerr); end
    checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL bp_last got=%b exp=1000", lasts); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_early_exit();
    burst_t w, got;
    logic [3:0] lasts;
    int ok_cnt, n, fhs, serr, rerr, s0;
    w = '{8'h01, 8'h02, 8'h03, 8'h04};
    s0 = swap_cnt;
    send_burst(w, 0, 1'b0, ok_cnt);
    drain_burst(0, got, lasts, n, fhs, serr, rerr);
    checks++; if (fhs != EXP_SORTED_LAT) begin failures++; $display("FAIL early_latency got=%0d exp=%0d", fhs, EXP_SORTED_LAT); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== w[i]) begin failures++; $display("FAIL early_word%0d got=%h exp=%h", i, got[i], w[i]); end
    end
    checks++; if (swap_cnt - s0 != 0) begin failures++; $display("FAIL early_swaps got=%0d exp=0", swap_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    burst_t w, exp, got;
    logic [3:0] lasts;
    int ok_cnt, n, fhs, serr, rerr, stray;
    w = '{8'h88, 8'h77, 8'h66, 8'h55};
    send_burst(w, 0, 1'b0, ok_cnt);
    tick();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_during out_valid=%b in_ready=%b exp 0/0", out_valid, in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_after in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL midrst_aborted got=%0d valid cycles exp=0", stray); end
    w   = '{8'h22, 8'h11, 8'h44, 8'h33};
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_burst(w, 0, 1'b0, ok_cnt);
    drain_burst(0, got, lasts, n, fhs, serr, rerr);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL midrst_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_gapped();
    burst_t w, exp, got;
    logic [3:0] lasts;
    int ok_cnt, n, fhs, serr, rerr;
    w   = '{8'h5A, 8'h0C, 8'hC3, 8'h0B};
    exp = '{8'h0B, 8'h0C, 8'h5A, 8'hC3};
    send_burst(w, 2, 1'b1, ok_cnt);
    checks++; if (ok_cnt != 4) begin failures++; $display("FAIL gap_accept got=%0d exp=4", ok_cnt); end
    drain_burst(0, got, lasts, n, fhs, serr, rerr);
    checks++; if (n != 4) begin failures++; $display("FAIL gap_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL gap_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    w   = '{8'h03, 8'h02, 8'h01, 8'h00};
    exp = '{8'h00, 8'h01, 8'h02, 8'h03};
    send_burst(w, 1, 1'b0, ok_cnt);
    drain_burst(0, got, lasts, n, fhs, serr, rerr);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL gap_next_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL gap_next_last got=%b exp=1000", lasts); end
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_early_exit();
    test_reset_mid();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
